// File: rtl/brisc_pkg.sv
// Shared types for the memory subsystem.
// Covers the line-sized memory request/response structs and the memory arbiter enums.
package brisc_pkg;

   localparam int ADDR_W          = 32;
   localparam int LINE_W          = 128;
   localparam int MEM_ARB_TIMEOUT = 64;

   typedef struct packed {
      logic              valid;
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } mem_req_t;

   typedef struct packed {
      logic              ready;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } mem_resp_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      PORT_ICACHE = 1'b0,
      PORT_DCACHE = 1'b1
   } arb_port_e;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin pick.
// On a tie, the port that did not win last time is chosen.
module rr_picker2
   import brisc_pkg::*;
(
   input  logic [1:0] valid,
   input  arb_port_e  last,
   output logic       any,
   output arb_port_e  winner
);

   always_comb begin
      any = |valid;
      case (valid)
         2'b11:   winner = (last == PORT_ICACHE) ? PORT_DCACHE : PORT_ICACHE;
         2'b10:   winner = PORT_DCACHE;
         default: winner = PORT_ICACHE;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives the icache and dcache shared use of one memory port.
// It registers the granted request, steers the reply back to its owner, and raises a sticky watchdog flag.
module mem_arbiter
   import brisc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = MEM_ARB_TIMEOUT
)
(
   input  logic      clk,
   input  logic      rst_n,
   input  mem_req_t  icache_req_i,
   input  mem_req_t  dcache_req_i,
   output mem_resp_t icache_resp_o,
   output mem_resp_t dcache_resp_o,
   output mem_req_t  mem_req_o,
   input  mem_resp_t mem_resp_i,
   output logic      busy_o,
   output logic      grant_o,
   output logic      timeout_o
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

   arb_state_e      state_q, state_d;
   mem_req_t        req_q, req_d;
   arb_port_e       grant_q, grant_d;
   arb_port_e       last_q, last_d;
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;

   logic [1:0]      req_valid;
   logic            pick_any;
   arb_port_e       pick_winner;

   assign req_valid = {dcache_req_i.valid, icache_req_i.valid};

   rr_picker2 u_picker (
      .valid  (req_valid),
      .last   (last_q),
      .any    (pick_any),
      .winner (pick_winner)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      grant_d   = grant_q;
      last_d    = last_q;
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               req_d       = (pick_winner == PORT_DCACHE) ? dcache_req_i : icache_req_i;
               req_d.valid = 1'b1;
               grant_d     = pick_winner;
               last_d      = pick_winner;
               wd_cnt_d    = '0;
               state_d     = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            // A ready in the limit cycle completes the transaction without flagging a timeout.
            if (mem_resp_i.ready) begin
               req_d.valid = 1'b0;
               state_d     = ARB_IDLE;
            end else begin
               if (wd_cnt_q >= WD_LAST) begin
                  timeout_d = 1'b1;
               end
               if (wd_cnt_q != WD_MAX) begin
                  wd_cnt_d = wd_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         req_q     <= '0;
         grant_q   <= PORT_ICACHE;
         last_q    <= PORT_DCACHE;
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign mem_req_o = req_q;
   assign busy_o    = (state_q == ARB_BUSY);
   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;

   // Only the owner of an outstanding transaction sees the reply; idle noise is masked.
   always_comb begin
      icache_resp_o = '0;
      dcache_resp_o = '0;
      if (state_q == ARB_BUSY) begin
         if (grant_q == PORT_DCACHE) begin
            dcache_resp_o = mem_resp_i;
         end else begin
            icache_resp_o = mem_resp_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard testbench for mem_arbiter.
// Directed stimulus pushes expected grants and replies into queues, and a negedge monitor pops and compares them.
module tb_mem_arbiter;
   import brisc_pkg::*;

   localparam int TO = 16;

   logic      clk = 1'b0;
   logic      rst_n;
   mem_req_t  icacheReq, dcacheReq, memReq;
   mem_resp_t icacheResp, dcacheResp, memResp;
   logic      busy, grant, timeout;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .icache_req_i  (icacheReq),
      .dcache_req_i  (dcacheReq),
      .icache_resp_o (icacheResp),
      .dcache_resp_o (dcacheResp),
      .mem_req_o     (memReq),
      .mem_resp_i    (memResp),
      .busy_o        (busy),
      .grant_o       (grant),
      .timeout_o     (timeout)
   );

   typedef struct {
      logic              port;
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } expT;

   expT  grantQ[$];
   expT  respQ[$];
   expT  monEntry;
   int   nChecks = 0;
   int   nFails  = 0;
   logic prevValid = 1'b0;

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                              input logic [LINE_W-1:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [LINE_W-1:0] lineOf(input int i);
      logic [31:0] w;
      w = 32'hC0DE0000 + 32'(i);
      return {4{w}};
   endfunction

   task automatic applyStimulus(input logic port, input logic valid, input logic rw,
                                input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
      mem_req_t r;
      r.valid = valid;
      r.rw    = rw;
      r.addr  = addr;
      r.data  = data;
      if (port) dcacheReq = r;
      else      icacheReq = r;
   endtask

   task automatic expectTxn(input logic port, input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
      expT g;
      expT r;
      g.port = port; g.rw = rw; g.addr = addr; g.data = wdata;
      r.port = port; r.rw = rw; r.addr = addr; r.data = rdata;
      grantQ.push_back(g);
      respQ.push_back(r);
   endtask

   task automatic serveMem(input int waitCycles, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] data);
      repeat (waitCycles) tick();
      memResp.ready = 1'b1;
      memResp.addr  = addr;
      memResp.data  = data;
      tick();
      memResp = '0;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      icacheReq = '0;
      dcacheReq = '0;
      memResp   = '0;
      grantQ.delete();
      respQ.delete();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_req_valid"}, LINE_W'(memReq.valid), '0);
      checkOutput({tag, "_req_addr"}, LINE_W'(memReq.addr), '0);
      checkOutput({tag, "_req_data"}, memReq.data, '0);
      checkOutput({tag, "_busy"}, LINE_W'(busy), '0);
      checkOutput({tag, "_grant"}, LINE_W'(grant), '0);
      checkOutput({tag, "_timeout"}, LINE_W'(timeout), '0);
      checkOutput({tag, "_iresp_ready"}, LINE_W'(icacheResp.ready), '0);
      checkOutput({tag, "_iresp_data"}, icacheResp.data, '0);
      checkOutput({tag, "_dresp_ready"}, LINE_W'(dcacheResp.ready), '0);
      checkOutput({tag, "_dresp_data"}, dcacheResp.data, '0);
   endtask

   // Monitor: every reply pulse and every new memory request must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (icacheResp.ready || dcacheResp.ready) begin
            checkOutput("resp_one_hot", LINE_W'(icacheResp.ready & dcacheResp.ready), '0);
            checkOutput("resp_expected", LINE_W'(respQ.size() != 0), LINE_W'(1));
            if (respQ.size() != 0) begin
               monEntry = respQ.pop_front();
               checkOutput("resp_port", LINE_W'(dcacheResp.ready), LINE_W'(monEntry.port));
               if (dcacheResp.ready) begin
                  checkOutput("dresp_data", dcacheResp.data, monEntry.data);
                  checkOutput("dresp_addr", LINE_W'(dcacheResp.addr), LINE_W'(monEntry.addr));
                  checkOutput("iresp_idle_data", icacheResp.data, '0);
               end else begin
                  checkOutput("iresp_data", icacheResp.data, monEntry.data);
                  checkOutput("iresp_addr", LINE_W'(icacheResp.addr), LINE_W'(monEntry.addr));
                  checkOutput("dresp_idle_data", dcacheResp.data, '0);
               end
            end
         end
         if (memReq.valid && !prevValid) begin
            checkOutput("grant_expected", LINE_W'(grantQ.size() != 0), LINE_W'(1));
            if (grantQ.size() != 0) begin
               monEntry = grantQ.pop_front();
               checkOutput("grant_port", LINE_W'(grant), LINE_W'(monEntry.port));
               checkOutput("grant_addr", LINE_W'(memReq.addr), LINE_W'(monEntry.addr));
               checkOutput("grant_rw", LINE_W'(memReq.rw), LINE_W'(monEntry.rw));
               checkOutput("grant_data", memReq.data, monEntry.data);
               checkOutput("grant_busy", LINE_W'(busy), LINE_W'(1));
            end
         end
      end
      prevValid = rst_n ? memReq.valid : 1'b0;
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_time_limit: simulation did not finish, expected finish before 100000");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      rst_n     = 1'b0;
      icacheReq = '0;
      dcacheReq = '0;
      memResp   = '0;
      #2;
      checkResetState("por");
      tick();
      tick();
      rst_n = 1'b1;

      // Single icache read, memory answers after a long delay
      expectTxn(1'b0, 1'b0, 32'h1000, '0, {16{8'hA5}});
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000, '0);
      sample();
      checkOutput("read_valid_before_grant", LINE_W'(memReq.valid), '0);
      tick();
      sample();
      checkOutput("read_busy", LINE_W'(busy), LINE_W'(1));
      checkOutput("read_grant", LINE_W'(grant), '0);
      serveMem(10, 32'h1000, {16{8'hA5}});
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      sample();
      checkOutput("read_busy_after_ready", LINE_W'(busy), '0);
      checkOutput("read_iresp_one_cycle", LINE_W'(icacheResp.ready), '0);

      // Reply noise while idle must not reach either cache
      memResp.ready = 1'b1;
      memResp.addr  = 32'hDEAD0000;
      memResp.data  = {4{32'hFFFF0000}};
      sample();
      checkOutput("idle_iresp_ready", LINE_W'(icacheResp.ready), '0);
      checkOutput("idle_dresp_ready", LINE_W'(dcacheResp.ready), '0);
      tick();
      sample();
      checkOutput("idle_busy", LINE_W'(busy), '0);
      checkOutput("idle_iresp_data", icacheResp.data, '0);
      tick();
      memResp = '0;

      // Both ports valid from reset: grants alternate starting with icache
      doReset();
      for (int i = 0; i < 4; i++) begin
         expectTxn(i[0], 1'b0, i[0] ? 32'h4000 : 32'h2000, '0, lineOf(i));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h2000, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000, '0);
      for (int i = 0; i < 4; i++) begin
         tick();
         sample();
         checkOutput("tie_grant", LINE_W'(grant), LINE_W'(i[0]));
         checkOutput("tie_addr", LINE_W'(memReq.addr), LINE_W'(i[0] ? 32'h4000 : 32'h2000));
         serveMem(2, i[0] ? 32'h4000 : 32'h2000, lineOf(i));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      sample();
      checkOutput("tie_busy_end", LINE_W'(busy), '0);

      // Dcache write-back holds the port while an icache request waits
      expectTxn(1'b1, 1'b1, 32'h4010, {4{32'h0BADF00D}}, '0);
      expectTxn(1'b0, 1'b0, 32'h1040, '0, lineOf(77));
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h4010, {4{32'h0BADF00D}});
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h1040, '0);
      for (int k = 0; k < 4; k++) begin
         sample();
         checkOutput("wb_hold_addr", LINE_W'(memReq.addr), LINE_W'(32'h4010));
         checkOutput("wb_hold_rw", LINE_W'(memReq.rw), LINE_W'(1));
         checkOutput("wb_hold_grant", LINE_W'(grant), LINE_W'(1));
         tick();
      end
      serveMem(0, 32'h4010, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      sample();
      checkOutput("wb_idle_gap", LINE_W'(busy), '0);
      tick();
      sample();
      checkOutput("wb_then_icache_grant", LINE_W'(grant), '0);
      serveMem(1, 32'h1040, lineOf(77));
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

      // Watchdog: memory stays silent past the limit, then finally answers
      doReset();
      expectTxn(1'b0, 1'b0, 32'h3000, '0, lineOf(5));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h3000, '0);
      tick();
      for (int k = 1; k <= 20; k++) begin
         sample();
         if (k == 16) checkOutput("wd_not_yet", LINE_W'(timeout), '0);
         if (k == 17) checkOutput("wd_set", LINE_W'(timeout), LINE_W'(1));
         if (k == 20) checkOutput("wd_sticky", LINE_W'(timeout), LINE_W'(1));
         tick();
      end
      serveMem(0, 32'h3000, lineOf(5));
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      sample();
      checkOutput("wd_late_complete_busy", LINE_W'(busy), '0);
      checkOutput("wd_sticky_after_complete", LINE_W'(timeout), LINE_W'(1));

      // Watchdog boundary: ready arrives in exactly the limit cycle
      doReset();
      sample();
      checkOutput("wd_cleared_by_reset", LINE_W'(timeout), '0);
      tick();
      expectTxn(1'b0, 1'b0, 32'h3100, '0, lineOf(6));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h3100, '0);
      tick();
      serveMem(15, 32'h3100, lineOf(6));
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      sample();
      checkOutput("wd_edge_no_timeout", LINE_W'(timeout), '0);
      tick();
      tick();
      sample();
      checkOutput("wd_edge_still_clear", LINE_W'(timeout), '0);
      tick();

      // Asynchronous reset in the middle of a transaction
      monEntry.port = 1'b0; monEntry.rw = 1'b0; monEntry.addr = 32'h5000; monEntry.data = '0;
      grantQ.push_back(monEntry);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h5000, '0);
      tick();
      sample();
      checkOutput("midreset_valid_before", LINE_W'(memReq.valid), LINE_W'(1));
      #1;
      rst_n = 1'b0;
      icacheReq = '0;
      #1;
      checkResetState("async_reset");
      respQ.delete();
      tick();
      rst_n = 1'b1;
      expectTxn(1'b0, 1'b0, 32'h5040, '0, lineOf(9));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h5040, '0);
      sample();
      checkOutput("postreset_valid_t", LINE_W'(memReq.valid), '0);
      tick();
      sample();
      checkOutput("postreset_valid_t1", LINE_W'(memReq.valid), LINE_W'(1));
      serveMem(1, 32'h5040, lineOf(9));
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();

      checkOutput("queues_drained", LINE_W'(grantQ.size() + respQ.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single main-memory port between the instruction cache (port 0) and the data cache (port 1). It accepts line-sized `mem_req_t` requests (refills and write-backs), grants one at a time in round-robin order, and registers the granted request toward memory. It routes the `mem_resp_t` reply back to the granted cache only, and flags a sticky timeout if memory fails to answer. It sits between the two caches and the memory model, and is the only master on the memory port.

## Interface
- `TIMEOUT_CYCLES`, default 64: BUSY cycles without `mem_resp_i.ready` before `timeout_o` sets; must be at least `MEM_REQ_DELAY + MEM_RESP_DELAY + 2`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `icache_req_i` input, `mem_req_t`: port 0 request; level `valid`.
- `dcache_req_i` input, `mem_req_t`: port 1 request; level `valid`.
- `icache_resp_o` output, `mem_resp_t`: port 0 response; `ready` pulses only for port 0 transactions.
- `dcache_resp_o` output, `mem_resp_t`: port 1 response.
- `mem_req_o` output, `mem_req_t`: registered request to memory.
- `mem_resp_i` input, `mem_resp_t`: memory reply; `ready` marks completion of a read or a write.
- `busy_o` output, 1 bit: a transaction is outstanding (state BUSY).
- `grant_o` output, 1 bit: port owning the current or most recent transaction (0 = icache, 1 = dcache).
- `timeout_o` output, 1 bit: sticky watchdog error.

## Operation
- FSM states are `ARB_IDLE` and `ARB_BUSY`. Reset enters IDLE.
- **IDLE.** If any `valid` is high, pick a winner, latch the winner's full `mem_req_t` into `req_q`, set `grant_q` to the winner, clear `wd_cnt`, and go to BUSY. Otherwise stay in IDLE.
- **Round-robin pick.**
  - Only one port valid: that port wins.
  - Both ports valid: the port not equal to `last_q` wins.
  - `last_q` updates to the winner on every grant.
  - `last_q` resets to 1, so port 0 wins the first tie.
- **BUSY.**
  - `mem_req_o` equals `req_q` with `valid = 1`, held stable for the whole transaction.
  - New requests are not sampled and non-granted ports wait.
  - When `mem_resp_i.ready = 1`, go to IDLE.
- **Response routing** (combinational):
  - The granted port's resp_o carries `mem_resp_i.addr`/`data`, with `ready = mem_resp_i.ready && busy`.
  - The other port gets `ready = 0` and `data`/`addr` = 0.
  - In IDLE, both ready outputs are 0, regardless of `mem_resp_i`.
- **Requester contract.** A cache deasserts `valid` or presents a new request in the cycle after it sees `ready`. The arbiter does not filter stale requests.
- **Watchdog.**
  - `wd_cnt` increments each BUSY cycle that has no ready.
  - When `wd_cnt` reaches `TIMEOUT_CYCLES - 1` with no ready, `timeout_o` sets on the next edge and stays set until reset.
  - The transaction keeps waiting; the watchdog never aborts it.
  - If ready arrives in the same cycle the limit is hit, ready wins and `timeout_o` does not set.
  - `wd_cnt` saturates at `TIMEOUT_CYCLES`, so there is no wrap-around.
- **Reset mid-transaction.** Abandon the transaction immediately and return to IDLE. Memory is assumed reset alongside.

## Timing
- Reset values: `mem_req_o` all zero (`valid = 0`), `busy_o = 0`, `grant_o = 0`, `timeout_o = 0`, both resp_o all zero, `last_q = 1`, `wd_cnt = 0`.
- Request seen in IDLE in cycle t: `mem_req_o.valid = 1` and `busy_o = 1` from cycle t+1. Grant overhead is 1 cycle.
- `mem_resp_i.ready` in cycle r: the granted resp_o has `ready = 1` in cycle r (zero latency). `busy_o = 0` from r+1.
- Back-to-back: the IDLE cycle r+1 can grant, giving a new `mem_req_o.valid` at r+2. There is a minimum of 1 idle cycle between transactions.
- With a continuous dual request, grants alternate 0, 1, 0, 1, so no starvation. Worst-case wait is one full transaction of the other port.
- `mem_req_o` is fully registered; no input-to-`mem_req_o` combinational path.

## Structure
- Add to `brisc_pkg`:
  - `arb_state_e` with `ARB_IDLE` and `ARB_BUSY`.
  - `arb_port_e` with `PORT_ICACHE = 0` and `PORT_DCACHE = 1`.
  - `MEM_ARB_TIMEOUT` = 64, used as the top-level override.
- Reuse the existing `mem_req_t` and `mem_resp_t` types.
- One combinational sub-module, `rr_picker2`:
  - inputs: `valid[1:0]`, `last`;
  - outputs: `any`, `winner`.
  - It is unit-testable on its own.

## Test plan
- **Reset.** Assert `rst_n = 0` mid-BUSY with `mem_req_o.valid = 1` -> all outputs zero immediately (asynchronous). After release, an icache request at t gives `mem_req_o.valid` at t+1.
- **Single icache read.** Icache `addr = 0x1000`, `rw = 0`; memory returns ready 10 cycles later with `data = 0xA5...` -> `icache_resp_o.ready = 1` for exactly one cycle with that data, `dcache_resp_o.ready` stays 0, `grant_o = 0`.
- **Tie and alternation.** Both ports valid from reset, each re-requesting the cycle after its ready -> grant sequence is 0, 1, 0, 1. `mem_req_o.addr` alternates between the icache address and the dcache address (e.g. `0x4000`).
- **Write-back isolation.** Dcache `rw = 1` at `0x4010` while icache requests 1 cycle later -> `mem_req_o` stays `0x4010`/`rw = 1` until ready. The icache request is granted in the IDLE cycle after.
- **Watchdog.** With `TIMEOUT_CYCLES = 16`, memory never readies -> `timeout_o` rises after 16 BUSY cycles and stays high. A later ready still completes the transaction. In a separate run, ready on cycle 16 exactly -> `timeout_o` stays 0.
- **Idle noise.** `mem_resp_i.ready = 1` while in IDLE -> both resp_o ready outputs remain 0.
